// File: rtl/pword_tx_pkg.sv
// Shared types and constants for the password-digit transmitter.
// The AUTO_LOAD state exists only when PWORD_TX_AUTO_EN is defined.
package pword_tx_pkg;

  localparam int DIGIT_W        = 4;
  localparam int CNT_W          = 3;
  localparam int MAX_DIGITS     = 7;
  localparam int CODE_W         = DIGIT_W * MAX_DIGITS;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int GAP_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    GAP       = 3'd3,
    WAIT_REL  = 3'd4
`ifdef PWORD_TX_AUTO_EN
    , AUTO_LOAD = 3'd5
`endif
  } state_t;

  // Nibble idx of a packed code, counting from the most-significant used
  // nibble (position 'last') downwards.
  function automatic logic [DIGIT_W-1:0] code_nibble(
    input logic [CODE_W-1:0] code,
    input logic [CNT_W-1:0]  idx,
    input logic [CNT_W-1:0]  last
  );
    logic [4:0]        sh;
    logic [CODE_W-1:0] shifted;
    sh      = {3'(last - idx), 2'b00};
    shifted = code >> sh;
    return shifted[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an active-low push-button, released (1) at reset,
// with a one-cycle pulse on each 1->0 transition of the synchronized level.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign fall  = r_prev & ~r_sync;

endmodule

// File: rtl/pword_tx.sv
// Password-digit transmitter: button/switch sampling into a registered digit
// and a one-cycle active-low enter strobe. Optional auto-send: PWORD_TX_AUTO_EN.
module pword_tx
  import pword_tx_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
`ifdef PWORD_TX_AUTO_EN
  , parameter logic [CODE_W-1:0] AUTO_CODE = 28'h0003153
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter_btn,
  input  logic               cancel,
`ifdef PWORD_TX_AUTO_EN
  input  logic               auto_req,
`endif
  output logic [DIGIT_W-1:0] pword,
  output logic               pword_enter,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               seq_done,
  output logic               busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [DIGIT_W-1:0] r_pword;
  logic [DIGIT_W-1:0] w_load_val;
  logic               w_load;
  logic [CNT_W-1:0]   r_digit_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_next;
  logic               r_seq_done;
  logic               w_done_next;
  logic               r_enter;
  logic               w_level;
  logic               w_fall;
`ifdef PWORD_TX_AUTO_EN
  logic               r_auto;
  logic               w_auto_next;
`endif

  btn_sync_edge u_btn (
    .clk   (CLK),
    .rst_n (RST),
    .btn   (enter_btn),
    .level (w_level),
    .fall  (w_fall)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_digit_cnt;
    w_gap_next   = r_gap_cnt;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_load_val   = digit_in;
`ifdef PWORD_TX_AUTO_EN
    w_auto_next  = r_auto;
`endif
    if (cancel) begin
      // Abort wins over everything, including a press arriving in IDLE.
      w_state_next = WAIT_REL;
      w_cnt_next   = '0;
`ifdef PWORD_TX_AUTO_EN
      w_auto_next  = 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef PWORD_TX_AUTO_EN
          if (auto_req && (r_digit_cnt == '0)) begin
            w_state_next = AUTO_LOAD;
            w_load       = 1'b1;
            w_load_val   = code_nibble(AUTO_CODE, '0, LAST_DIGIT);
            w_auto_next  = 1'b1;
          end else
`endif
          if (w_fall) begin
            w_state_next = LOAD;
            w_load       = 1'b1;
          end
        end
        LOAD: w_state_next = SEND;
`ifdef PWORD_TX_AUTO_EN
        AUTO_LOAD: w_state_next = SEND;
`endif
        SEND: begin
          w_state_next = GAP;
          w_gap_next   = '0;
          if (r_digit_cnt == LAST_DIGIT) begin
            w_cnt_next  = '0;
            w_done_next = 1'b1;
          end else begin
            w_cnt_next  = r_digit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
`ifdef PWORD_TX_AUTO_EN
            // Auto-send chains digits directly; a wrapped count marks the end.
            if (r_auto) begin
              if (r_digit_cnt == '0) begin
                w_state_next = IDLE;
                w_auto_next  = 1'b0;
              end else begin
                w_state_next = AUTO_LOAD;
                w_load       = 1'b1;
                w_load_val   = code_nibble(AUTO_CODE, r_digit_cnt, LAST_DIGIT);
              end
            end else
`endif
            w_state_next = WAIT_REL;
          end else begin
            w_gap_next = r_gap_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (w_level) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_pword     <= '0;
      r_digit_cnt <= '0;
      r_gap_cnt   <= '0;
      r_seq_done  <= 1'b0;
      r_enter     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_digit_cnt <= w_cnt_next;
      r_gap_cnt   <= w_gap_next;
      r_seq_done  <= w_done_next;
      r_enter     <= (w_state_next != SEND);
      if (w_load) begin
        r_pword <= w_load_val;
      end
    end
  end

`ifdef PWORD_TX_AUTO_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_auto <= 1'b0;
    end else begin
      r_auto <= w_auto_next;
    end
  end
`endif

  assign pword       = r_pword;
  assign pword_enter = r_enter;
  assign digit_cnt   = r_digit_cnt;
  assign seq_done    = r_seq_done;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pword_tx.sv
// Directed + randomized bench for pword_tx; the auto-send run is compiled
// only when PWORD_TX_AUTO_EN is defined.
module tb_pword_tx;

  localparam int N = 4;
  localparam int G = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter_btn = 1'b1;
  logic       cancel = 1'b0;
`ifdef PWORD_TX_AUTO_EN
  logic       auto_req = 1'b0;
`endif
  logic [3:0] pword;
  logic       pword_enter;
  logic [2:0] digit_cnt;
  logic       seq_done;
  logic       busy;

  pword_tx #(.NUM_DIGITS(N), .GAP_CYCLES(G)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .digit_in    (digit_in),
    .enter_btn   (enter_btn),
    .cancel      (cancel),
`ifdef PWORD_TX_AUTO_EN
    .auto_req    (auto_req),
`endif
    .pword       (pword),
    .pword_enter (pword_enter),
    .digit_cnt   (digit_cnt),
    .seq_done    (seq_done),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc++;

  // Observed strobes and seq_done pulses.
  logic [3:0] act_q[$];
  int         act_cyc_q[$];
  int         act_done = 0;
  int         wide_cnt = 0;
  int         misalign = 0;
  bit         prev_low = 1'b0;
  bit         prev_done = 1'b0;

  // Reference model: one strobe per accepted press, count wraps at N.
  logic [3:0] exp_q[$];
  int         exp_cnt = 0;
  int         exp_done = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (!pword_enter) begin
        act_q.push_back(pword);
        act_cyc_q.push_back(cyc);
        if (prev_low) wide_cnt++;
      end
      if (seq_done) begin
        act_done++;
        if (!prev_low || prev_done) misalign++;
      end
      prev_low  = !pword_enter;
      prev_done = seq_done;
    end else begin
      prev_low  = 1'b0;
      prev_done = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_press(input logic [3:0] d);
    exp_q.push_back(d);
    if (exp_cnt == N - 1) begin
      exp_cnt = 0;
      exp_done++;
    end else begin
      exp_cnt++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_timeout", busy, 0);
    repeat (2) step();
  endtask

  task automatic check_press(input string tag);
    chk({tag, "_n_strobes"}, act_q.size(), exp_q.size());
    if (act_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_digit"}, act_q[$], exp_q[$]);
    chk({tag, "_digit_cnt"}, digit_cnt, exp_cnt);
    chk({tag, "_seq_done_n"}, act_done, exp_done);
    chk({tag, "_strobe_width"}, wide_cnt, 0);
    chk({tag, "_seq_done_align"}, misalign, 0);
    $display("press %s digit=%0d strobes=%0d digit_cnt=%0d seq_done=%0d",
             tag, exp_q.size() > 0 ? exp_q[$] : 4'd0, act_q.size(), digit_cnt, act_done);
  endtask

  task automatic press(input logic [3:0] d, input int bounce, input int hold);
    digit_in = d;
    for (int b = 0; b < bounce; b++) begin
      enter_btn = 1'b0;
      step();
      enter_btn = 1'b1;
      step();
    end
    enter_btn = 1'b0;
    repeat (hold) step();
    enter_btn = 1'b1;
    model_press(d);
    wait_idle();
  endtask

  task automatic clear_model();
    act_q.delete();
    act_cyc_q.delete();
    exp_q.delete();
    exp_cnt   = 0;
    exp_done  = 0;
    act_done  = 0;
    wide_cnt  = 0;
    misalign  = 0;
  endtask

  logic [3:0] seq_digits[4] = '{4'd3, 4'd1, 4'd5, 4'd3};
  logic [3:0] d;
  int         s0;

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_pword", pword, 0);
    chk("rst_enter", pword_enter, 1);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_busy", busy, 0);
    RST = 1'b1;
    repeat (3) step();

    // Exact latency: digit 3, button low for 20 cycles from edge k
    digit_in  = 4'd3;
    enter_btn = 1'b0;
    step();
    step();
    chk("k1_busy", busy, 0);
    chk("k1_pword", pword, 0);
    step();
    chk("k2_pword", pword, 3);
    chk("k2_enter", pword_enter, 1);
    chk("k2_busy", busy, 1);
    step();
    chk("k3_enter", pword_enter, 0);
    chk("k3_pword", pword, 3);
    step();
    chk("k4_enter", pword_enter, 1);
    chk("k4_cnt", digit_cnt, 1);
    repeat (16) step();
    enter_btn = 1'b1;
    model_press(4'd3);
    wait_idle();
    check_press("held20");

    // Reset asserted in the middle of a strobe
    digit_in  = 4'($urandom_range(1, 15));
    enter_btn = 1'b0;
    for (int i = 0; i < 10 && pword_enter !== 1'b0; i++) step();
    chk("mid_pre_strobe", pword_enter, 0);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_enter", pword_enter, 1);
    chk("mid_rst_pword", pword, 0);
    chk("mid_rst_cnt", digit_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", seq_done, 0);
    $display("reset mid-strobe enter=%0d pword=%0d cnt=%0d", pword_enter, pword, digit_cnt);
    enter_btn = 1'b1;
    repeat (2) step();
    RST = 1'b1;
    clear_model();
    repeat (3) step();

    // Sequence 3,1,5,3 with two bounce cycles per press
    for (int i = 0; i < 4; i++) begin
      press(seq_digits[i], 2, $urandom_range(2, 10));
      check_press($sformatf("seq%0d", i));
    end

    // Randomized presses
    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom_range(0, 15));
      press(d, $urandom_range(0, 2), $urandom_range(1, 12));
      check_press($sformatf("rnd%0d", i));
    end

    // Two digits, then cancel together with a press in IDLE
    for (int i = 0; i < 2; i++) begin
      d = 4'($urandom_range(0, 15));
      press(d, 0, $urandom_range(2, 6));
      check_press($sformatf("pre_cancel%0d", i));
    end
    digit_in  = 4'($urandom_range(0, 15));
    enter_btn = 1'b0;
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    exp_cnt = 0;
    repeat (8) step();
    chk("cancel_no_strobe", act_q.size(), exp_q.size());
    chk("cancel_cnt", digit_cnt, 0);
    chk("cancel_busy", busy, 1);
    enter_btn = 1'b1;
    wait_idle();
    chk("cancel_idle_cnt", digit_cnt, 0);
    $display("cancel strobes=%0d digit_cnt=%0d", act_q.size(), digit_cnt);
    d = 4'($urandom_range(0, 15));
    press(d, 1, 4);
    check_press("post_cancel");

`ifdef PWORD_TX_AUTO_EN
    // Auto-send of the default code, with a button press during the run
    for (int i = 0; i < N && exp_cnt != 0; i++) begin
      d = 4'($urandom_range(0, 15));
      press(d, 0, 3);
      check_press($sformatf("pre_auto%0d", i));
    end
    begin
      logic [15:0] code;
      int          d0;
      code = 16'h3153;
      s0   = act_q.size();
      d0   = act_done;
      auto_req = 1'b1;
      step();
      auto_req = 1'b0;
      repeat (3) step();
      enter_btn = 1'b0;
      repeat (4) step();
      enter_btn = 1'b1;
      for (int i = 0; i < 80 && busy; i++) step();
      repeat (10) step();
      chk("auto_n", act_q.size() - s0, N);
      for (int i = 0; i < N; i++) begin
        if (s0 + i < act_q.size()) begin
          chk($sformatf("auto_digit%0d", i), act_q[s0 + i], 4'((code >> (4 * (N - 1 - i))) & 16'hF));
          if (i > 0)
            chk($sformatf("auto_gap%0d", i), act_cyc_q[s0 + i] - act_cyc_q[s0 + i - 1], 2 + G);
          $display("auto strobe %0d pword=%0d cycle=%0d", i, act_q[s0 + i], act_cyc_q[s0 + i]);
        end
      end
      chk("auto_done", act_done - d0, 1);
      chk("auto_cnt", digit_cnt, 0);
      chk("auto_align", misalign, 0);
      chk("auto_busy", busy, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pword_tx.md
# pword_tx

Password-digit transmitter: the driving end of the `pword`/`pword_enter` digit-entry interface that the access-control FSM consumes. It samples a 4-bit digit from the board switches when the entry button is pressed and presents it as a registered digit plus a single-cycle active-low enter strobe. It enforces a minimum gap between strobes, tracks how many digits are in the current sequence, and flags the end of each sequence. It sits between the raw board I/O (switches, push-button) and the access block.

## Interface

- `NUM_DIGITS`, default 4: digits per password sequence; legal range 1..7.
- `GAP_CYCLES`, default 3: minimum high cycles on `pword_enter` after each strobe; must be ≥ 1.
- `AUTO_CODE`, default 16'h3153: digit sequence for auto-send, most-significant nibble sent first; used only with `PWORD_TX_AUTO_EN`.
- `CLK` input 1: single clock, all logic on posedge.
- `RST` input 1: asynchronous, active-low reset.
- `digit_in` input 4: digit from the switches, sampled when a press is detected.
- `enter_btn` input 1: raw push-button, active-low (0 = pressed), asynchronous to `CLK`.
- `cancel` input 1: synchronous, active-high; aborts the sequence in progress.
- `auto_req` input 1: present only with `PWORD_TX_AUTO_EN`; one-cycle active-high request.
- `pword` output 4: registered digit; stable from the LOAD cycle until the next LOAD.
- `pword_enter` output 1: active-low strobe, idle high, low for exactly one cycle per digit.
- `digit_cnt` output 3: digits sent in the current sequence, 0..NUM_DIGITS-1.
- `seq_done` output 1: one-cycle high pulse in the cycle after the NUM_DIGITS-th strobe.
- `busy` output 1: high in every state except IDLE.

## Operation

- Reset values:
  - `pword` = 0, `pword_enter` = 1, `digit_cnt` = 0, `seq_done` = 0, `busy` = 0.
  - Synchronizer flops = 1 (released). FSM = IDLE.
- Press detection: 2-flop synchronizer on `enter_btn`. A press is a 1→0 transition on the synchronized signal. Bounce is suppressed by the GAP and WAIT_REL states.
- FSM states:
  - IDLE: on press, go to LOAD and latch `pword` ← `digit_in`.
  - LOAD: `pword_enter` = 1 (setup cycle). Go to SEND.
  - SEND: `pword_enter` = 0.
    - If `digit_cnt` == NUM_DIGITS-1: clear `digit_cnt` and pulse `seq_done` next cycle.
    - Otherwise increment `digit_cnt`.
    - Go to GAP.
  - GAP: hold `pword_enter` = 1 for GAP_CYCLES cycles, counted by the gap counter. Then go to WAIT_REL.
  - WAIT_REL: stay until the synchronized button is high, then go to IDLE.
- A button held indefinitely produces exactly one strobe; there is no auto-repeat.
- Presses seen in LOAD, SEND, GAP or WAIT_REL are ignored.
- `cancel`:
  - Highest synchronous priority.
  - Next edge: FSM → WAIT_REL, `digit_cnt` = 0, `pword_enter` = 1, no `seq_done`.
  - `pword` keeps its value.
- Reset assertion mid-sequence forces all outputs to their reset values immediately (asynchronously). This includes an in-flight strobe, which ends at once.
- Simultaneous press and `cancel` in IDLE: `cancel` wins and no LOAD occurs.

## Timing

- Raw `enter_btn` falls and is first sampled low at edge k:
  - Synchronized low at k+1.
  - LOAD (`pword` valid) after k+2.
  - `pword_enter` low after k+3, high again after k+4.
- `pword` is valid one full cycle before the strobe and during it; the consumer samples both in the same cycle.
- Minimum strobe-to-strobe spacing: 2 + GAP_CYCLES + (WAIT_REL dwell ≥ 1) + 2 sync cycles.

## Configuration

- Macro `PWORD_TX_AUTO_EN`.
- Defined:
  - Port `auto_req` exists.
  - `auto_req` is honored only in IDLE with `digit_cnt` == 0.
  - On an honored request, sends all NUM_DIGITS nibbles of AUTO_CODE, MS nibble first, through LOAD→SEND→GAP with no button involvement and WAIT_REL skipped. Period is 2 + GAP_CYCLES cycles per digit.
  - `seq_done` pulses after the last digit. `cancel` aborts as in manual mode.
  - Presses during auto-send are ignored.
- Undefined: no `auto_req` port, AUTO_CODE unused, manual entry only.

## Structure

- Package `pword_tx_pkg` holds:
  - The state enum: IDLE, LOAD, SEND, GAP, WAIT_REL, plus AUTO_LOAD under the macro.
  - Digit width (4) and counter width (3).
  - Default values of NUM_DIGITS and GAP_CYCLES.
- One sub-module, `btn_sync_edge`:
  - 2-flop synchronizer with reset value 1.
  - Outputs: `level` (synchronized) and `fall` (one-cycle falling-edge pulse).

## Test plan

- Reset asserted mid-strobe → `pword_enter` goes 1 immediately; `pword` = 0, `digit_cnt` = 0, `busy` = 0, `seq_done` = 0.
- `digit_in` = 3, button low for 20 cycles from edge k → `pword` = 3 after k+2, `pword_enter` low only in cycle k+3..k+4, `digit_cnt` = 1, one strobe total.
- Digits 3, 1, 5, 3 pressed in turn, with the button bouncing 0/1 for 2 cycles at each press → exactly 4 strobes carrying 3, 1, 5, 3; `seq_done` high one cycle after the 4th strobe; `digit_cnt` back to 0.
- Two digits sent, then `cancel` coinciding with a fresh press in IDLE → no strobe, `digit_cnt` = 0; the next press produces a strobe with `digit_cnt` → 1.
- `PWORD_TX_AUTO_EN` defined, GAP_CYCLES = 3, `auto_req` pulsed → strobes with `pword` = 3, 1, 5, 3 at 5-cycle spacing; `seq_done` follows the last strobe; a button press during the run has no effect.
